// File: rtl/bg_tile_fetcher_if.sv
// Background tile fetcher bus: scanline control, name/pattern table
// lookups and the serialized pixel stream.
interface bg_tile_fetcher_if;
    logic       start_line;
    logic [7:0] line_y;
    logic [9:0] nt_addr;
    logic [7:0] nt_tile;
    logic [7:0] tile_num;
    logic [2:0] yoffset;
    logic [7:0] line0;
    logic [7:0] line1;
    logic [1:0] pixel;
    logic       pixel_valid;
    logic       busy;
    logic       line_done;

    modport master (
        output start_line, line_y, nt_tile, line0, line1,
        input  nt_addr, tile_num, yoffset, pixel, pixel_valid,
        input  busy, line_done
    );

    modport slave (
        input  start_line, line_y, nt_tile, line0, line1,
        output nt_addr, tile_num, yoffset, pixel, pixel_valid,
        output busy, line_done
    );
endinterface

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: fetches one tile ahead through name and pattern
// tables while an 8-cycle slot serializes the current tile, MSB first.
module bg_tile_fetcher #(
    parameter int TILES_PER_LINE = 32,
    parameter int PT_LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rst,
    bg_tile_fetcher_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PREFETCH, RUN} state_t;

    localparam logic [4:0] LAST_COL = 5'(TILES_PER_LINE - 1);
    localparam logic [2:0] PT_SLOT  = 3'(PT_LATENCY);

    state_t     r_state;
    state_t     w_next;
    logic       w_start;
    logic       w_slot_end;
    logic [7:0] r_y;
    logic [4:0] r_col;
    logic [2:0] r_slot;
    logic       r_fetch;
    logic       r_drain;
    logic [7:0] r_lat0, r_lat1;
    logic [7:0] r_sh0, r_sh1;
    logic [9:0] r_nt_addr;
    logic [7:0] r_tile_num;
    logic [2:0] r_yoff;
    logic [1:0] r_pixel;
    logic       r_pvalid;
    logic       r_busy;
    logic       r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A start in the line_done cycle is refused so the previous line closes cleanly.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_slot_end = (r_slot == 3'd7);
        unique case (r_state)
            IDLE: begin
                if (bus.start_line && !r_done) begin
                    w_start = 1'b1;
                    w_next  = PREFETCH;
                end
            end
            PREFETCH: if (w_slot_end) w_next = RUN;
            RUN:      if (r_drain) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y        <= '0;
            r_col      <= '0;
            r_slot     <= '0;
            r_fetch    <= 1'b0;
            r_drain    <= 1'b0;
            r_lat0     <= '0;
            r_lat1     <= '0;
            r_sh0      <= '0;
            r_sh1      <= '0;
            r_nt_addr  <= '0;
            r_tile_num <= '0;
            r_yoff     <= '0;
            r_pixel    <= '0;
            r_pvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start) begin
                    r_y       <= bus.line_y;
                    r_col     <= '0;
                    r_slot    <= '0;
                    r_fetch   <= 1'b1;
                    r_drain   <= 1'b0;
                    r_busy    <= 1'b1;
                    r_nt_addr <= {bus.line_y[7:3], 5'd0};
                end
            end else begin
                r_slot <= r_slot + 3'd1;
                if (r_fetch && r_slot == 3'd0) begin
                    r_tile_num <= bus.nt_tile;
                    r_yoff     <= r_y[2:0];
                end
                if (r_fetch && r_slot == PT_SLOT) begin
                    r_lat0 <= bus.line0;
                    r_lat1 <= bus.line1;
                end
                if (r_state == RUN) begin
                    if (r_drain) begin
                        r_drain  <= 1'b0;
                        r_pvalid <= 1'b0;
                        r_pixel  <= 2'b00;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_pvalid <= 1'b1;
                        r_pixel  <= {r_sh1[7], r_sh0[7]};
                        r_sh0    <= {r_sh0[6:0], 1'b0};
                        r_sh1    <= {r_sh1[6:0], 1'b0};
                    end
                end
                if (w_slot_end && !r_drain) begin
                    if (r_state == RUN && !r_fetch) begin
                        r_drain <= 1'b1;
                    end else begin
                        r_sh0 <= r_lat0;
                        r_sh1 <= r_lat1;
                        if (r_col == LAST_COL) begin
                            r_fetch <= 1'b0;
                        end else begin
                            r_col     <= r_col + 5'd1;
                            r_nt_addr <= {r_y[7:3], r_col + 5'd1};
                        end
                    end
                end
            end
        end
    end

    assign bus.nt_addr     = r_nt_addr;
    assign bus.tile_num    = r_tile_num;
    assign bus.yoffset     = r_yoff;
    assign bus.pixel       = r_pixel;
    assign bus.pixel_valid = r_pvalid;
    assign bus.busy        = r_busy;
    assign bus.line_done   = r_done;
endmodule

// File: doc/bg_tile_fetcher.md
BG_TILE_FETCHER -- requirements
Module: bg_tile_fetcher

Interface
REQ-001 Parameter TILES_PER_LINE, default 32, SHALL set the tiles fetched and serialized per scanline.
REQ-002 Parameter PT_LATENCY, default 2, SHALL set the cycles from tile_num/yoffset driven to line0/line1 valid.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start_line  input  1  SHALL be a one-cycle pulse requesting a scanline fetch.
REQ-006 line_y  input  8  SHALL give the scanline number and is sampled with start_line.
REQ-007 nt_addr  output  10  SHALL be the name-table address {y[7:3], tile column[4:0]}.
REQ-008 nt_tile  input  8  SHALL be the name-table tile index, valid 1 cycle after nt_addr changes.
REQ-009 tile_num  output  8  SHALL be the pattern-table tile index.
REQ-010 yoffset  output  3  SHALL be the pattern-table row within the tile (captured y[2:0]).
REQ-011 line0 / line1  input  8 each  SHALL be pattern bitplane 0 / 1, valid PT_LATENCY cycles after tile_num/yoffset.
REQ-012 pixel  output  2  SHALL be the current pixel index {plane1 bit, plane0 bit}.
REQ-013 pixel_valid  output  1  SHALL be high in each cycle pixel carries a scanline pixel.
REQ-014 busy  output  1  SHALL be high from start acceptance until line_done.
REQ-015 line_done  output  1  SHALL pulse one cycle after the last pixel of a line.

Function
REQ-016 States SHALL be IDLE, PREFETCH, RUN; all outputs are registered.
REQ-017 IDLE + start_line=1 SHALL capture line_y, clear tile column and slot counter, enter PREFETCH, raise busy.
REQ-018 Each tile SHALL use an 8-cycle slot (counter 0..7): slot 0 drive nt_addr; slot 1 register nt_tile onto tile_num with yoffset; slot 1+PT_LATENCY register line0/line1 into next-tile latch.
REQ-019 PREFETCH SHALL fetch column 0 in one slot, then at slot 7 load latch into shifter and enter RUN.
REQ-020 RUN SHALL emit one pixel per cycle, MSB first: pixel = {plane1[7-i], plane0[7-i]}, i = slot count 0..7.
REQ-021 During RUN, tile column c+1 SHALL be fetched in the slot serializing column c; shifter reloads from latch at each slot-7 boundary.
REQ-022 Column TILES_PER_LINE-1 SHALL NOT trigger a further fetch; nt_addr holds its last value.
REQ-023 pixel_valid SHALL be high for exactly 8*TILES_PER_LINE consecutive cycles, first pixel 9 cycles after the start_line sampling edge.
REQ-024 After the last pixel, line_done SHALL pulse one cycle, busy drops in that cycle, and the state returns to IDLE.
REQ-025 start_line while busy SHALL be ignored without disturbing the line in progress.
REQ-026 start_line coincident with line_done SHALL be ignored; start is accepted only in IDLE.
REQ-027 Tile column counter SHALL be 5 bits and never wrap within a line.
REQ-028 When pixel_valid is low, pixel SHALL be 2'b00.

Reset
REQ-029 rst SHALL force IDLE and zero nt_addr, tile_num, yoffset, pixel, pixel_valid, busy, line_done, latches, and counters immediately.
REQ-030 rst mid-line SHALL abort the line with no line_done; the first start_line after rst release starts a fresh line.

Verification
REQ-031 Pattern model with latency 2, nt_tile = column, tile t rows = {8'hF0,8'h0F}; line_y=0 -> pixels 1,1,1,1,2,2,2,2 per tile, 256 valid cycles, one line_done.
REQ-032 line_y=8'd77 -> every nt_addr = {5'd9, col}, yoffset = 3'd5 throughout.
REQ-033 line0=8'h80, line1=8'h01 on all tiles -> per tile pixel sequence 1,0,0,0,0,0,0,2.
REQ-034 start_line re-pulsed at pixel 100 -> no restart, still 256 pixels, single line_done.
REQ-035 rst asserted at pixel 50 -> all outputs 0 in that cycle, no line_done; new start yields full 256-pixel line.
REQ-036 Back-to-back start_line on the cycle after line_done -> accepted, first pixel 9 cycles later.
